// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte sources,
// with bounded bursts per grant and a watchdog that aborts a stuck frame.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 8,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 12500,
    localparam int IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner,
    output logic                      err_timeout,
    output logic [IDX_W-1:0]          err_src
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BC_W-1:0]  BURST_MAX = BC_W'(MAX_BURST);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  last_grant, last_grant_nxt;
    logic [BC_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [WD_W-1:0]   wdog, wdog_nxt;
    logic [N_REQ-1:0]  ack_nxt;
    logic              tx_start_nxt;
    logic [DATA_W-1:0] tx_data_nxt;
    logic [IDX_W-1:0]  owner_nxt;
    logic              err_timeout_nxt;
    logic [IDX_W-1:0]  err_src_nxt;

    logic [DATA_W-1:0] req_bytes [N_REQ];
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  cand;
    logic              done;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    // A tx_done coinciding with our own start pulse belongs to a previous frame.
    assign done = tx_done && !tx_start;

    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        burst_cnt_nxt   = burst_cnt;
        wdog_nxt        = wdog;
        ack_nxt         = '0;
        tx_start_nxt    = 1'b0;
        tx_data_nxt     = tx_data;
        owner_nxt       = owner;
        err_timeout_nxt = 1'b0;
        err_src_nxt     = err_src;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    owner_nxt     = winner;
                    tx_data_nxt   = req_bytes[winner];
                    ack_nxt       = ONE_HOT0 << winner;
                    tx_start_nxt  = 1'b1;
                    burst_cnt_nxt = BC_W'(1);
                    wdog_nxt      = '0;
                    state_nxt     = S_WAIT;
                end
            end
            S_WAIT: begin
                wdog_nxt = wdog + 1'b1;
                if (done) begin
                    if (req[owner] && (burst_cnt < BURST_MAX)) begin
                        tx_data_nxt   = req_bytes[owner];
                        ack_nxt       = ONE_HOT0 << owner;
                        tx_start_nxt  = 1'b1;
                        burst_cnt_nxt = burst_cnt + 1'b1;
                        wdog_nxt      = '0;
                    end else begin
                        last_grant_nxt = owner;
                        state_nxt      = S_IDLE;
                    end
                end else if (wdog == WD_LAST) begin
                    err_timeout_nxt = 1'b1;
                    err_src_nxt     = owner;
                    last_grant_nxt  = owner;
                    state_nxt       = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= LAST_INIT;
            burst_cnt   <= '0;
            wdog        <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            owner       <= '0;
            err_timeout <= 1'b0;
            err_src     <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            burst_cnt   <= burst_cnt_nxt;
            wdog        <= wdog_nxt;
            ack         <= ack_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            owner       <= owner_nxt;
            err_timeout <= err_timeout_nxt;
            err_src     <= err_src_nxt;
            busy        <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1,
// both driven by the same inputs; each scenario checks the instance it targets.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int T  = 12500;

    logic          clk, rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic          tx_done;

    logic [N-1:0]  ack4, ack1;
    logic          tx_start4, tx_start1;
    logic [DW-1:0] tx_data4, tx_data1;
    logic          busy4, busy1;
    logic [1:0]    owner4, owner1;
    logic          err_timeout4, err_timeout1;
    logic [1:0]    err_src4, err_src1;

    int tests = 0;
    int fails = 0;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4), .TIMEOUT_CYCLES(T)) u4 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack4),
        .tx_start(tx_start4), .tx_data(tx_data4), .tx_done(tx_done), .busy(busy4),
        .owner(owner4), .err_timeout(err_timeout4), .err_src(err_src4)
    );

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(1), .TIMEOUT_CYCLES(T)) u1 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack1),
        .tx_start(tx_start1), .tx_data(tx_data1), .tx_done(tx_done), .busy(busy1),
        .owner(owner1), .err_timeout(err_timeout1), .err_src(err_src1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req_data = '0;
        tx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic frame_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Requester model for the burst scenario: each ack pops one byte.
    logic [7:0] q0 [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic [7:0] q1 [2] = '{8'hB0, 8'hB1};
    int p0, p1;

    task automatic update_reqs();
        if (ack4[0] && p0 < 6) p0++;
        if (ack4[1] && p1 < 2) p1++;
        req = {2'b00, (p1 < 2), (p0 < 6)};
        req_data = {16'h0000, (p1 < 2) ? q1[p1] : 8'h00, (p0 < 6) ? q0[p0] : 8'h00};
    endtask

    logic [7:0] exp_byte [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
    logic [1:0] exp_own  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};

    initial begin
        logic [3:0] e;
        int n;

        // Reset state
        rst = 1'b1;
        req = '0;
        req_data = '0;
        tx_done = 1'b0;
        tick();
        tick();
        check("rst_ack", ack4, 0);
        check("rst_tx_start", tx_start4, 0);
        check("rst_tx_data", tx_data4, 0);
        check("rst_busy", busy4, 0);
        check("rst_owner", owner4, 0);
        check("rst_err", err_timeout4, 0);
        check("rst_err_src", err_src4, 0);
        rst = 1'b0;

        // 1: single byte from requester 0
        req = 4'b0001;
        req_data = {24'h0, 8'hA5};
        tick();
        check("t1_ack", ack4, 4'b0001);
        check("t1_start", tx_start4, 1);
        check("t1_data", tx_data4, 8'hA5);
        check("t1_busy", busy4, 1);
        req = '0;
        req_data = '0;
        tick();
        check("t1_ack_low", ack4, 0);
        check("t1_start_low", tx_start4, 0);
        repeat (99) tick();
        check("t1_busy_wait", busy4, 1);
        frame_done();
        check("t1_busy_done", busy4, 0);
        check("t1_data_hold", tx_data4, 8'hA5);

        // 2: fairness with MAX_BURST=1, all requesting
        do_reset();
        req = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 6; i++) begin
            tick();
            e = 4'b0001 << (i % 4);
            check("t2_owner", owner1, i % 4);
            check("t2_ack", ack1, e);
            check("t2_start", tx_start1, 1);
            check("t2_data", tx_data1, 8'h10 + (i % 4));
            tick();
            frame_done();
            check("t2_idle", busy1, 0);
        end

        // 3: bursts of at most 4, rotating to requester 1 and back
        do_reset();
        p0 = 0;
        p1 = 0;
        update_reqs();
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!tx_start4 && n < 20) begin
                tick();
                update_reqs();
                n++;
            end
            check("t3_start", tx_start4, 1);
            check("t3_data", tx_data4, exp_byte[k]);
            check("t3_owner", owner4, exp_own[k]);
            tick();
            update_reqs();
            frame_done();
            update_reqs();
        end
        tick();
        check("t3_end_busy", busy4, 0);

        // 4: watchdog abort on requester 2, next grant goes to 3
        do_reset();
        req = 4'b0100;
        req_data = {8'hD3, 8'hC2, 16'h0000};
        tick();
        check("t4_owner", owner4, 2);
        check("t4_data", tx_data4, 8'hC2);
        req = 4'b1100;
        repeat (T - 1) tick();
        check("t4_no_err_yet", err_timeout4, 0);
        check("t4_busy_yet", busy4, 1);
        tick();
        check("t4_err", err_timeout4, 1);
        check("t4_err_src", err_src4, 2);
        check("t4_busy_low", busy4, 0);
        tick();
        check("t4_err_pulse", err_timeout4, 0);
        check("t4_next_owner", owner4, 3);
        check("t4_next_ack", ack4, 4'b1000);
        check("t4_next_data", tx_data4, 8'hD3);

        // 5: tx_done on the watchdog terminal count completes normally
        req = '0;
        repeat (T - 1) tick();
        check("t5_busy_pre", busy4, 1);
        frame_done();
        check("t5_no_err", err_timeout4, 0);
        check("t5_busy", busy4, 0);
        tick();
        check("t5_no_err_late", err_timeout4, 0);
        check("t5_err_src_hold", err_src4, 2);

        // 6: asynchronous reset in the middle of WAIT
        req = 4'b0010;
        req_data = {16'h0000, 8'h5B, 8'h00};
        tick();
        check("t6_owner", owner4, 1);
        req = '0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_busy", busy4, 0);
        check("t6_owner_rst", owner4, 0);
        check("t6_data_rst", tx_data4, 0);
        check("t6_err_src_rst", err_src4, 0);
        check("t6_ack_rst", ack4, 0);
        #1 rst = 1'b0;
        req = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        check("t6_first_owner", owner4, 0);
        check("t6_first_ack", ack4, 4'b0001);
        check("t6_first_data", tx_data4, 8'h11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
